// File: rtl/memory_arbiter.sv
// Shares one word memory between instruction fetch and data (load/store/amoadd.w)
// requesters: round-robin on conflict, amoadd.w runs as a locked read-modify-write.
module memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_SHIFT  = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_address,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic                  dm_amo,
  input  logic [DATA_WIDTH-1:0] dm_address,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ready,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_input_data,
  output logic                  mem_write,
  output logic                  mem_read,
  output logic                  mem_type,
  input  logic [DATA_WIDTH-1:0] mem_output_data,
  output logic [2:0]            o_dbg_state
);

  localparam logic MEM_ROM = 1'b0;
  localparam logic MEM_RAM = 1'b1;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DREAD  = 3'd2;
  localparam logic [2:0] S_DWRITE = 3'd3;
  localparam logic [2:0] S_AMO_RD = 3'd4;
  localparam logic [2:0] S_AMO_WR = 3'd5;

  // Handshake: a requester holds req and its request fields stable until its
  // ready pulses for one cycle; req still high during that pulse is not a new request.
  logic [2:0]            r_state;
  logic                  r_last_grant;
  logic                  r_if_ready;
  logic                  r_dm_ready;
  logic [DATA_WIDTH-1:0] r_if_data;
  logic [DATA_WIDTH-1:0] r_dm_rdata;
  logic [DATA_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_input_data;
  logic                  r_mem_write;
  logic                  r_mem_read;
  logic                  r_mem_type;

  logic w_if_elig;
  logic w_dm_elig;
  logic w_conflict;
  logic w_grant_dm;

  assign w_if_elig  = if_req & ~r_if_ready;
  assign w_dm_elig  = dm_req & ~r_dm_ready;
  assign w_conflict = w_if_elig & w_dm_elig;
  assign w_grant_dm = w_dm_elig & (~w_if_elig | (r_last_grant == GRANT_FETCH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_last_grant     <= GRANT_FETCH;
      r_if_ready       <= 1'b0;
      r_dm_ready       <= 1'b0;
      r_if_data        <= '0;
      r_dm_rdata       <= '0;
      r_mem_address    <= '0;
      r_mem_input_data <= '0;
      r_mem_write      <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_type       <= MEM_ROM;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant_dm) begin
            r_mem_address    <= dm_address >> IDX_SHIFT;
            r_mem_type       <= MEM_RAM;
            r_mem_input_data <= dm_wdata;
            if (w_conflict) r_last_grant <= GRANT_DATA;
            if (dm_amo) begin
              r_mem_read <= 1'b1;
              r_state    <= S_AMO_RD;
            end else if (dm_we) begin
              r_mem_write <= 1'b1;
              r_state     <= S_DWRITE;
            end else begin
              r_mem_read <= 1'b1;
              r_state    <= S_DREAD;
            end
          end else if (w_if_elig) begin
            r_mem_address    <= if_address >> IDX_SHIFT;
            r_mem_type       <= MEM_ROM;
            r_mem_input_data <= '0;
            r_mem_read       <= 1'b1;
            r_state          <= S_FETCH;
            if (w_conflict) r_last_grant <= GRANT_FETCH;
          end
        end
        S_FETCH: begin
          r_if_data  <= mem_output_data;
          r_if_ready <= 1'b1;
          r_mem_read <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_DREAD: begin
          r_dm_rdata <= mem_output_data;
          r_dm_ready <= 1'b1;
          r_mem_read <= 1'b0;
          r_state    <= S_IDLE;
        end
        S_DWRITE: begin
          r_dm_ready  <= 1'b1;
          r_mem_write <= 1'b0;
          r_state     <= S_IDLE;
        end
        S_AMO_RD: begin
          // The FSM stays out of IDLE until the write-back, which keeps fetch locked out.
          r_dm_rdata       <= mem_output_data;
          r_mem_input_data <= mem_output_data + dm_wdata;
          r_mem_read       <= 1'b0;
          r_mem_write      <= 1'b1;
          r_state          <= S_AMO_WR;
        end
        S_AMO_WR: begin
          r_dm_ready  <= 1'b1;
          r_mem_write <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign if_ready       = r_if_ready;
  assign if_data        = r_if_data;
  assign dm_ready       = r_dm_ready;
  assign dm_rdata       = r_dm_rdata;
  assign mem_address    = r_mem_address;
  assign mem_input_data = r_mem_input_data;
  assign mem_write      = r_mem_write;
  assign mem_read       = r_mem_read;
  assign mem_type       = r_mem_type;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural ROM/RAM (read on negedge,
// write on posedge) and expected-data queues per requester.
module tb_memory_arbiter;

  localparam logic MEM_ROM = 1'b0;
  localparam logic MEM_RAM = 1'b1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DREAD  = 3'd2;
  localparam logic [2:0] S_AMO_WR = 3'd5;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        if_req = 1'b0;
  logic [31:0] if_address = '0;
  logic        if_ready;
  logic [31:0] if_data;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic        dm_amo = 1'b0;
  logic [31:0] dm_address = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic [31:0] mem_address;
  logic [31:0] mem_input_data;
  logic        mem_write;
  logic        mem_read;
  logic        mem_type;
  logic [31:0] mem_output_data = '0;
  logic [2:0]  dbg_state;

  memory_arbiter #(.DATA_WIDTH(32), .IDX_SHIFT(2)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_address(if_address), .if_ready(if_ready), .if_data(if_data),
    .dm_req(dm_req), .dm_we(dm_we), .dm_amo(dm_amo), .dm_address(dm_address),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_type(mem_type),
    .mem_output_data(mem_output_data), .o_dbg_state(dbg_state)
  );

  // memory model
  function automatic logic [31:0] rom_word(input logic [31:0] idx);
    return 32'h1000_0000 + idx * 32'h0000_0101;
  endfunction

  logic [31:0] ram [0:15] = '{default: 32'h0};

  always @(negedge clock) begin
    if (mem_read)
      mem_output_data <= (mem_type == MEM_ROM) ? rom_word(mem_address) : ram[mem_address[3:0]];
  end

  always @(posedge clock) begin
    if (mem_write && mem_type == MEM_RAM) ram[mem_address[3:0]] <= mem_input_data;
  end

  // bus activity counters, sampled on the cycle that just closed
  int n_rd = 0;
  int n_wr = 0;
  int n_rom = 0;
  int n_both = 0;
  always @(posedge clock) begin
    if (mem_read) n_rd <= n_rd + 1;
    if (mem_write) n_wr <= n_wr + 1;
    if (mem_read && mem_type == MEM_ROM) n_rom <= n_rom + 1;
    if (mem_read && mem_write) n_both <= n_both + 1;
  end

  // scoreboard
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] if_exp_q[$];
  logic [31:0] dm_exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // driver tasks
  task automatic issue_fetch(input logic [31:0] addr);
    if_req = 1'b1;
    if_address = addr;
    if_exp_q.push_back(rom_word(addr >> 2));
  endtask

  task automatic issue_data(input logic we, input logic amo, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
    dm_req = 1'b1;
    dm_we = we;
    dm_amo = amo;
    dm_address = addr;
    dm_wdata = wdata;
    if (amo || !we) dm_exp_q.push_back(exp_rdata);
  endtask

  task automatic wait_if(input string tag, input int exp_cyc);
    int cyc = 0;
    do begin @(negedge clock); cyc++; end while (!if_ready && cyc < 10);
    check({tag, "_if_ready"}, {31'b0, if_ready}, 32'd1);
    check({tag, "_if_latency"}, cyc, exp_cyc);
    if (if_exp_q.size() > 0) check({tag, "_if_data"}, if_data, if_exp_q.pop_front());
    if_req = 1'b0;
  endtask

  task automatic wait_dm(input string tag, input int exp_cyc);
    int cyc = 0;
    do begin @(negedge clock); cyc++; end while (!dm_ready && cyc < 10);
    check({tag, "_dm_ready"}, {31'b0, dm_ready}, 32'd1);
    check({tag, "_dm_latency"}, cyc, exp_cyc);
    if (dm_amo || !dm_we) begin
      if (dm_exp_q.size() > 0) check({tag, "_dm_rdata"}, dm_rdata, dm_exp_q.pop_front());
    end
    dm_req = 1'b0;
    dm_amo = 1'b0;
    dm_we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {27'b0, if_ready, dm_ready, mem_read, mem_write, mem_type}, 32'd0);
    check({tag, "_if_data"}, if_data, 32'd0);
    check({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    check({tag, "_mem_addr"}, mem_address, 32'd0);
    check({tag, "_mem_wdata"}, mem_input_data, 32'd0);
    check({tag, "_state"}, {29'b0, dbg_state}, {29'b0, S_IDLE});
  endtask

  initial begin
    int rd0;
    int wr0;
    int rom0;

    // reset state
    tick();
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();

    // 1: single fetch, index = addr >> 2
    rd0 = n_rd;
    issue_fetch(32'h10);
    tick();
    check("t1_addr", mem_address, 32'd4);
    check("t1_type", {31'b0, mem_type}, {31'b0, MEM_ROM});
    check("t1_read", {31'b0, mem_read}, 32'd1);
    check("t1_state", {29'b0, dbg_state}, {29'b0, S_FETCH});
    wait_if("t1", 1);
    check("t1_read_cycles", n_rd - rd0, 32'd1);
    tick();
    check("t1_ready_pulse", {31'b0, if_ready}, 32'd0);

    // 2: store then load
    wr0 = n_wr;
    issue_data(1'b1, 1'b0, 32'h0, 32'd10, 32'd0);
    tick();
    check("t2_write", {31'b0, mem_write}, 32'd1);
    check("t2_read_off", {31'b0, mem_read}, 32'd0);
    check("t2_type", {31'b0, mem_type}, {31'b0, MEM_RAM});
    check("t2_wdata", mem_input_data, 32'd10);
    wait_dm("t2_st", 1);
    check("t2_ram0", ram[0], 32'd10);
    check("t2_write_cycles", n_wr - wr0, 32'd1);
    tick();
    issue_data(1'b0, 1'b0, 32'h0, 32'd0, 32'd10);
    wait_dm("t2_ld", 2);
    tick();

    // 3: conflict after reset -> data first, then fetch first
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    issue_fetch(32'h8);
    issue_data(1'b0, 1'b0, 32'h0, 32'd0, 32'd10);
    tick();
    check("t3a_first_type", {31'b0, mem_type}, {31'b0, MEM_RAM});
    check("t3a_state", {29'b0, dbg_state}, {29'b0, S_DREAD});
    wait_dm("t3a", 1);
    wait_if("t3a", 2);
    tick();
    issue_fetch(32'h0E);
    issue_data(1'b0, 1'b0, 32'h0, 32'd0, 32'd10);
    tick();
    check("t3b_first_type", {31'b0, mem_type}, {31'b0, MEM_ROM});
    check("t3b_addr", mem_address, 32'd3);
    wait_if("t3b", 1);
    wait_dm("t3b", 2);
    tick();

    // 4: locked amoadd with fetch arriving mid-operation
    issue_data(1'b0, 1'b1, 32'h0, 32'd20, 32'd10);
    tick();
    rom0 = n_rom;
    issue_fetch(32'h14);
    tick();
    check("t4_state", {29'b0, dbg_state}, {29'b0, S_AMO_WR});
    check("t4_write", {31'b0, mem_write}, 32'd1);
    check("t4_read_off", {31'b0, mem_read}, 32'd0);
    check("t4_sum", mem_input_data, 32'd30);
    wait_dm("t4", 1);
    check("t4_ram0", ram[0], 32'd30);
    check("t4_no_rom_in_amo", n_rom - rom0, 32'd0);
    wait_if("t4", 2);
    tick();

    // 5: amoadd wraps modulo 2^32
    issue_data(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'd0);
    wait_dm("t5_st", 2);
    tick();
    issue_data(1'b0, 1'b1, 32'h0, 32'd2, 32'hFFFF_FFFF);
    wait_dm("t5_amo", 3);
    check("t5_ram0", ram[0], 32'h0000_0001);
    tick();

    // 6: async reset during DWRITE aborts the write
    issue_data(1'b1, 1'b0, 32'h4, 32'h55, 32'd0);
    tick();
    check("t6_write_pre", {31'b0, mem_write}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("t6_abort");
    tick();
    check("t6_ram1", ram[1], 32'd0);
    check("t6_no_ready", {31'b0, dm_ready}, 32'd0);
    dm_req = 1'b0;
    dm_we = 1'b0;
    reset = 1'b0;
    tick();
    issue_data(1'b1, 1'b0, 32'h4, 32'h55, 32'd0);
    wait_dm("t6_reissue", 2);
    check("t6_ram1_reissue", ram[1], 32'h55);
    tick();

    // global bus properties
    check("never_rd_and_wr", n_both, 32'd0);
    check("if_queue_empty", if_exp_q.size(), 32'd0);
    check("dm_queue_empty", dm_exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
